// File: rtl/bsg_blackparrot_halfpod_reset_seq.sv
// Core-clock reset sequencer for the BlackParrot half-pod SDR tile: releases token, uplink,
// downlink, downstream and core resets in timed order. Optional status ports: BSG_HALFPOD_RESET_SEQ_STATUS_EN.
module bsg_blackparrot_halfpod_reset_seq #(
  parameter int hold_cycles_p  = 16,
  parameter int y_cord_width_p = 7
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      async_en_i,
  input  logic [y_cord_width_p-1:0] async_y_cord_i,
  output logic                      sdr_token_reset_o,
  output logic                      sdr_uplink_reset_o,
  output logic                      sdr_downlink_reset_o,
  output logic                      sdr_downstream_reset_o,
  output logic                      core_reset_o,
  output logic [y_cord_width_p-1:0] global_y_cord_o,
  output logic                      ready_o
`ifdef BSG_HALFPOD_RESET_SEQ_STATUS_EN
  ,
  output logic [2:0]                status_o,
  output logic [7:0]                abort_cnt_o
`endif
);

  localparam int cnt_width_lp = $clog2(hold_cycles_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(hold_cycles_p - 1);

  typedef enum logic [2:0] {
    IDLE_S    = 3'd0,
    TOK_REL_S = 3'd1,
    UP_REL_S  = 3'd2,
    DN_REL_S  = 3'd3,
    DS_REL_S  = 3'd4,
    RUN_S     = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
  logic                      en_meta_q, en_meta_d;
  logic                      en_sync_q, en_sync_d;
  logic [y_cord_width_p-1:0] y_cord_q, y_cord_d;
  // {token, uplink, downlink, downstream, core}
  logic [4:0]                rst_q, rst_d;
  logic                      ready_q, ready_d;
  logic                      cnt_last;
  logic                      abort;
`ifdef BSG_HALFPOD_RESET_SEQ_STATUS_EN
  logic [7:0]                abort_cnt_q, abort_cnt_d;
`endif

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    en_meta_d = async_en_i;
    en_sync_d = en_meta_q;
    state_d   = state_q;
    y_cord_d  = y_cord_q;
    cnt_last  = (cnt_q == cnt_last_lp);
    abort     = (state_q != IDLE_S) && !en_sync_q;

    unique case (state_q)
      IDLE_S:    if (en_sync_q) state_d = TOK_REL_S;
      TOK_REL_S: if (cnt_last)  state_d = UP_REL_S;
      UP_REL_S:  if (cnt_last)  state_d = DN_REL_S;
      DN_REL_S:  if (cnt_last)  state_d = DS_REL_S;
      DS_REL_S:  if (cnt_last) begin
                   state_d  = RUN_S;
                   y_cord_d = async_y_cord_i;
                 end
      RUN_S:     state_d = RUN_S;
      default:   state_d = IDLE_S;
    endcase

    // A lost enable overrides any stage advance, including the capture edge.
    if (abort) begin
      state_d  = IDLE_S;
      y_cord_d = y_cord_q;
    end

    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q inside {TOK_REL_S, UP_REL_S, DN_REL_S, DS_REL_S})
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;

    // Outputs are decoded from the next state so they register on the same edge as the state.
    rst_d   = 5'b11111;
    ready_d = 1'b0;
    unique case (state_d)
      TOK_REL_S: rst_d = 5'b01111;
      UP_REL_S:  rst_d = 5'b00111;
      DN_REL_S:  rst_d = 5'b00011;
      DS_REL_S:  rst_d = 5'b00001;
      RUN_S: begin
        rst_d   = 5'b00000;
        ready_d = 1'b1;
      end
      default:   rst_d = 5'b11111;
    endcase

`ifdef BSG_HALFPOD_RESET_SEQ_STATUS_EN
    abort_cnt_d = abort_cnt_q;
    if (abort && (abort_cnt_q != 8'hFF))
      abort_cnt_d = abort_cnt_q + 8'd1;
`endif
  end

  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      en_meta_q <= 1'b0;
      en_sync_q <= 1'b0;
      state_q   <= IDLE_S;
      cnt_q     <= '0;
      y_cord_q  <= '0;
      rst_q     <= 5'b11111;
      ready_q   <= 1'b0;
`ifdef BSG_HALFPOD_RESET_SEQ_STATUS_EN
      abort_cnt_q <= 8'd0;
`endif
    end else begin
      en_meta_q <= en_meta_d;
      en_sync_q <= en_sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_cord_q  <= y_cord_d;
      rst_q     <= rst_d;
      ready_q   <= ready_d;
`ifdef BSG_HALFPOD_RESET_SEQ_STATUS_EN
      abort_cnt_q <= abort_cnt_d;
`endif
    end
  end

  assign sdr_token_reset_o      = rst_q[4];
  assign sdr_uplink_reset_o     = rst_q[3];
  assign sdr_downlink_reset_o   = rst_q[2];
  assign sdr_downstream_reset_o = rst_q[1];
  assign core_reset_o           = rst_q[0];
  assign ready_o                = ready_q;
  assign global_y_cord_o        = y_cord_q;

`ifdef BSG_HALFPOD_RESET_SEQ_STATUS_EN
  assign status_o    = state_q;
  assign abort_cnt_o = abort_cnt_q;
`endif

endmodule
